// File: rtl/icache_mem_pkg.sv
// Shared constants and responder state encoding for the instruction-cache
// block-fill interface; imported by both the cache controller and the responder.
package icache_mem_pkg;

  localparam int ADDR_WIDTH           = 16;
  localparam int MEM_DATA_WIDTH       = 40;
  localparam int NUM_MEM_TRANSACTIONS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2
  } resp_state_e;

endpackage

// File: rtl/mem_word_array.sv
// Word storage behind the block responder: one synchronous write port and one
// asynchronous read port; the consumer registers the read data.
module mem_word_array #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately left out of reset so it maps onto RAM
  // primitives and preserves loaded contents across a responder reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Reading combinationally here gives read-before-write when the consumer
  // registers this value on the same edge that a write lands.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_block_responder.sv
// Memory-side responder: accepts one block request, waits a fixed latency,
// then streams NUM_MEM_TRANSACTIONS consecutive words from the word array.
module mem_block_responder
  import icache_mem_pkg::*;
#(
  parameter int ADDR_WIDTH           = icache_mem_pkg::ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH       = icache_mem_pkg::MEM_DATA_WIDTH,
  parameter int NUM_MEM_TRANSACTIONS = icache_mem_pkg::NUM_MEM_TRANSACTIONS,
  parameter int DEPTH                = 4096,
  parameter int READ_LATENCY         = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_halt,
  input  logic [ADDR_WIDTH-1:0]     i_mem_req_addr,
  input  logic                      i_mem_req_valid,
  input  logic                      i_mem_ready,
  input  logic                      i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]  i_wr_addr,
  input  logic [MEM_DATA_WIDTH-1:0] i_wr_data,
  output logic                      o_req_ready,
  output logic [MEM_DATA_WIDTH-1:0] o_mem_data,
  output logic                      o_mem_data_valid,
  output logic                      o_req_dropped
);

  localparam int              IDX_W     = $clog2(DEPTH);
  localparam int              BEAT_W    = $clog2(NUM_MEM_TRANSACTIONS);
  localparam logic [3:0]      LAT_LOAD  = 4'(READ_LATENCY);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_MEM_TRANSACTIONS - 1);

  resp_state_e               state_q, state_d;
  logic [3:0]                lat_q, lat_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [MEM_DATA_WIDTH-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      drop_q, drop_d;

  logic [BEAT_W-1:0]         rd_beat;
  logic [IDX_W-1:0]          rd_addr;
  logic [MEM_DATA_WIDTH-1:0] rd_data;
  logic                      accept;

  mem_word_array #(
    .DEPTH (DEPTH),
    .WIDTH (MEM_DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (i_wr_en),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign o_req_ready = (state_q == ST_IDLE) && !i_halt && !rst;
  assign accept      = i_mem_req_valid && o_req_ready;

  // The word being fetched is the one registered at the coming edge; the
  // cast keeps only the low index bits so block addresses wrap modulo DEPTH.
  assign rd_beat = (state_q == ST_STREAM) ? beat_q + 1'b1 : '0;
  assign rd_addr = IDX_W'({addr_q, rd_beat});

  // NOTE: every signal assigned here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    if (!i_halt) begin
      drop_d = i_mem_req_valid && (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_d  = i_mem_req_addr;
            lat_d   = LAT_LOAD;
            beat_d  = '0;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_q != '0) begin
            lat_d = lat_q - 1'b1;
          end else if (i_mem_ready) begin
            data_d  = rd_data;
            valid_d = 1'b1;
            beat_d  = '0;
            state_d = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (beat_q == LAST_BEAT) begin
            data_d  = '0;
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            data_d = rd_data;
            beat_d = beat_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign o_mem_data       = data_q;
  assign o_mem_data_valid = valid_q;
  assign o_req_dropped    = drop_q;

endmodule

// File: doc/mem_block_responder.md
# mem_block_responder

Memory-side responder for the instruction-cache block-fill interface. Accepts one 16-bit block-address request at a time and, after a fixed access latency, streams the eight 40-bit words of that block on consecutive cycles. Backed by an internal loadable word array. Sits opposite the cache's memory controller, in both the system model and the FPGA/test top.

## Interface
- `ADDR_WIDTH`, 16: block address width.
- `MEM_DATA_WIDTH`, 40: beat (word) width.
- `NUM_MEM_TRANSACTIONS`, 8: beats per block; must be a power of two.
- `DEPTH`, 4096: array depth in words; must be a power of two and at least `NUM_MEM_TRANSACTIONS`.
- `READ_LATENCY`, 2: wait cycles from accept to first beat; legal range is 0..15.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `i_halt`  in  1  global freeze, shared with the cache.
- `i_mem_req_addr`  in  ADDR_WIDTH  block address.
- `i_mem_req_valid`  in  1  request strobe.
- `i_mem_ready`  in  1  requester is waiting for data.
- `i_wr_en`  in  1  array write enable (loader).
- `i_wr_addr`  in  $clog2(DEPTH)  word address.
- `i_wr_data`  in  MEM_DATA_WIDTH  write data.
- `o_req_ready`  out  1  responder can accept a request.
- `o_mem_data`  out  MEM_DATA_WIDTH  beat data.
- `o_mem_data_valid`  out  1  beat valid.
- `o_req_dropped`  out  1  one-cycle pulse when a request is presented while busy.

## Operation
- States: IDLE, WAIT, STREAM.
- **Accept:** occurs at an edge where `i_mem_req_valid & o_req_ready`.
  - `o_req_ready = (state==IDLE) & ~i_halt & ~rst`.
  - On accept: latch the address, load the latency counter with `READ_LATENCY`, clear the beat counter, and go to WAIT.
- **WAIT:** the counter decrements each unhalted cycle down to 0. When it is 0 and `i_mem_ready` is high, the next edge registers beat 0 and enters STREAM. If `i_mem_ready` is low, the block holds in WAIT indefinitely.
- **STREAM:** each edge registers the next beat.
  - After beat `NUM_MEM_TRANSACTIONS-1`, the next edge clears `o_mem_data_valid` and `o_mem_data` and returns to IDLE.
  - `i_mem_ready` is ignored once streaming starts.
  - Valid is never deasserted mid-block except by halt hold or reset.
- **Word index:** `{latched_addr, beat}` truncated to the low `$clog2(DEPTH)` bits, so the address wraps modulo DEPTH.
- **Busy requests:** a request with `state!=IDLE` is ignored and pulses `o_req_dropped` for one cycle. It is not queued.
- **Halt:** while `i_halt=1`, state, counters, and outputs hold their values; a held valid beat stays valid. Array writes still take effect during halt.
- **Write/read collision:** a write to the word being registered in the same cycle returns the old data (read-before-write).
- **Reset:** clears all outputs to 0 and returns to IDLE, including mid-stream. Array contents are not cleared.

## Timing
- With accept at edge T and `i_mem_ready` high, beat k is valid after edge T+READ_LATENCY+1+k.
  - `READ_LATENCY=0`: beat 0 follows edge T+1.
  - Default: beat 0 follows edge T+3, beat 7 follows edge T+10.
- Valid drops after edge T+READ_LATENCY+1+NUM_MEM_TRANSACTIONS. `o_req_ready` is high in that same cycle (if not halted).
- Each halted cycle delays all later events by exactly one cycle.
- Outputs are registered; only `o_req_ready` is combinational from state, `i_halt`, and `rst`.

## Structure
- **Shared package `icache_mem_pkg`:** `ADDR_WIDTH`, `MEM_DATA_WIDTH`, `NUM_MEM_TRANSACTIONS`, and the responder state encodings. The cache-side controller imports the same width constants.
- **Sub-module `mem_word_array`:** DEPTH×MEM_DATA_WIDTH storage with one synchronous write port and one asynchronous read port. The responder registers the read data.

## Test plan
- **Default fill:** load words 0x40..0x47 with data `0xA0_0000_0000+i`, then request block 8 at edge T → beats 0..7 carry those values, valid after edges T+3..T+10, and `o_req_ready` is 0 throughout.
- **Late ready:** hold `i_mem_ready=0` for 5 cycles after accept → the block waits in WAIT, and beat 0 appears exactly 1 edge after ready rises.
- **Halt mid-stream:** assert `i_halt` for 3 cycles while beat 3 is valid → beat 3 is held for 4 cycles total, beats 4..7 follow contiguously, and no beat is lost or duplicated.
- **Busy request:** issue a second request during WAIT → `o_req_dropped` pulses once, and the original block streams unchanged.
- **Reset mid-stream:** assert `rst` during beat 5 → valid and data read 0 next cycle, `o_req_ready` is 1 after `rst` drops, and a new request returns the array data intact.
- **Address wrap and collision:** with DEPTH=4096, request block 0x0200 → reads words 0..7. Writing word 2 in the cycle beat 2 registers → beat 2 carries the old value.
